// File: rtl/ws2812_rx_if.sv
// Port bundle for the WS2812 stream decoder: serial line in, decoded words and status out.
interface ws2812_rx_if #(
  parameter int PIX_W = 10
);
  logic             din;
  logic [23:0]      pixel;
  logic             pixel_valid;
  logic [PIX_W-1:0] pixel_index;
  logic             latch;
  logic             bit_error;
  logic             in_sync;

  modport master (
    output din,
    input  pixel, pixel_valid, pixel_index, latch, bit_error, in_sync
  );

  modport slave (
    input  din,
    output pixel, pixel_valid, pixel_index, latch, bit_error, in_sync
  );
endinterface

// File: rtl/ws2812_rx.sv
// WS2812B-style receive decoder: measures high-pulse widths on an oversampled line,
// packs bits MSB-first into 24-bit GRB words and detects the long-low latch gap.
module ws2812_rx #(
  parameter int THRESH       = 30,
  parameter int MIN_HIGH     = 5,
  parameter int MAX_HIGH     = 100,
  parameter int RESET_CYCLES = 2500,
  parameter int PIX_W        = 10
) (
  input  logic        Clock_50,
  input  logic        Reset,
  ws2812_rx_if.slave  bus
);

  localparam logic [7:0]  THRESH_C   = 8'(THRESH);
  localparam logic [7:0]  MIN_HIGH_C = 8'(MIN_HIGH);
  localparam logic [7:0]  MAX_HIGH_C = 8'(MAX_HIGH);
  localparam logic [11:0] RESET_C    = 12'(RESET_CYCLES);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  state_t           state, state_nx;
  logic             s1, s2;
  logic [7:0]       hi_cnt, hi_nx, hi_inc;
  logic [11:0]      lo_cnt, lo_nx, lo_inc;
  logic [4:0]       bitcnt, bit_nx;
  logic [PIX_W-1:0] idx_cnt, idx_nx;
  logic [23:0]      shreg, sh_nx, new_word;
  logic [23:0]      pixel_q, pixel_nx;
  logic [PIX_W-1:0] index_q, index_nx;
  logic             valid_q, valid_nx;
  logic             latch_q, latch_nx;
  logic             err_q, err_nx;
  logic             sync_q, sync_nx;

  assign hi_inc   = (hi_cnt == 8'hFF) ? hi_cnt : hi_cnt + 8'd1;
  assign lo_inc   = (lo_cnt == 12'hFFF) ? lo_cnt : lo_cnt + 12'd1;
  assign new_word = {shreg[22:0], (hi_cnt >= THRESH_C)};

  always_comb begin
    state_nx = state;
    hi_nx    = hi_cnt;
    lo_nx    = lo_cnt;
    bit_nx   = bitcnt;
    idx_nx   = idx_cnt;
    sh_nx    = shreg;
    pixel_nx = pixel_q;
    index_nx = index_q;
    valid_nx = 1'b0;
    latch_nx = 1'b0;
    err_nx   = 1'b0;
    case (state)
      SYNC: begin
        if (s2) begin
          lo_nx = '0;
        end else begin
          lo_nx = lo_inc;
          if (lo_inc == RESET_C) begin
            state_nx = IDLE;
            bit_nx   = '0;
            idx_nx   = '0;
          end
        end
      end
      IDLE: begin
        if (s2) begin
          state_nx = HIGH;
          hi_nx    = 8'd1;
        end
      end
      HIGH: begin
        if (s2) begin
          hi_nx = hi_inc;
          if (hi_inc == MAX_HIGH_C) begin
            err_nx   = 1'b1;
            bit_nx   = '0;
            idx_nx   = '0;
            lo_nx    = '0;
            state_nx = SYNC;
          end
        end else if (hi_cnt < MIN_HIGH_C) begin
          err_nx   = 1'b1;
          bit_nx   = '0;
          idx_nx   = '0;
          lo_nx    = '0;
          state_nx = SYNC;
        end else begin
          sh_nx = new_word;
          if (bitcnt == 5'd23) begin
            pixel_nx = new_word;
            index_nx = idx_cnt;
            valid_nx = 1'b1;
            bit_nx   = '0;
            idx_nx   = idx_cnt + 1'b1;
          end else begin
            bit_nx = bitcnt + 5'd1;
          end
          lo_nx    = 12'd1;
          state_nx = LOW;
        end
      end
      LOW: begin
        if (s2) begin
          state_nx = HIGH;
          hi_nx    = 8'd1;
        end else begin
          lo_nx = lo_inc;
          if (lo_inc == RESET_C) begin
            // a frame ending mid-word discards the partial bits and flags it
            latch_nx = 1'b1;
            err_nx   = (bitcnt != 5'd0);
            bit_nx   = '0;
            idx_nx   = '0;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = SYNC;
    endcase
    sync_nx = (state_nx != SYNC);
  end

  // Synchronizer resets high so a full low window must travel through both
  // flops after reset before SYNC starts counting toward alignment.
  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      state   <= SYNC;
      hi_cnt  <= '0;
      lo_cnt  <= '0;
      bitcnt  <= '0;
      idx_cnt <= '0;
      shreg   <= '0;
      pixel_q <= '0;
      index_q <= '0;
      valid_q <= 1'b0;
      latch_q <= 1'b0;
      err_q   <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      s1      <= bus.din;
      s2      <= s1;
      state   <= state_nx;
      hi_cnt  <= hi_nx;
      lo_cnt  <= lo_nx;
      bitcnt  <= bit_nx;
      idx_cnt <= idx_nx;
      shreg   <= sh_nx;
      pixel_q <= pixel_nx;
      index_q <= index_nx;
      valid_q <= valid_nx;
      latch_q <= latch_nx;
      err_q   <= err_nx;
      sync_q  <= sync_nx;
    end
  end

  assign bus.pixel       = pixel_q;
  assign bus.pixel_index = index_q;
  assign bus.pixel_valid = valid_q;
  assign bus.latch       = latch_q;
  assign bus.bit_error   = err_q;
  assign bus.in_sync     = sync_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: directed line waveforms, expected events queued at stimulus
// time and popped by an independent monitor whenever the decoder reports an event.
module tb_ws2812_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   last_fall = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  typedef struct {
    logic        pv;
    logic        lt;
    logic        er;
    logic [23:0] px;
    logic [9:0]  ix;
    int          at;
  } ev_t;

  ev_t q[$];

  ws2812_rx_if #(.PIX_W(10)) bus ();

  ws2812_rx dut (
    .Clock_50 (clk),
    .Reset    (rst),
    .bus      (bus)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (!rst && (bus.pixel_valid || bus.latch || bus.bit_error)) begin
      n_vec++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: got pv=%0b lt=%0b er=%0b px=%06h ix=%0d cyc=%0d, expected no event",
                 bus.pixel_valid, bus.latch, bus.bit_error, bus.pixel, bus.pixel_index, cyc);
      end else begin
        ev_t e;
        logic ok;
        e  = q.pop_front();
        ok = (bus.pixel_valid == e.pv) && (bus.latch == e.lt) && (bus.bit_error == e.er);
        if (e.pv && (bus.pixel != e.px || bus.pixel_index != e.ix)) ok = 1'b0;
        if (e.at >= 0 && cyc != e.at) ok = 1'b0;
        if (!ok) begin
          n_bad++;
          $display("FAIL event: got pv=%0b lt=%0b er=%0b px=%06h ix=%0d cyc=%0d, expected pv=%0b lt=%0b er=%0b px=%06h ix=%0d cyc=%0d",
                   bus.pixel_valid, bus.latch, bus.bit_error, bus.pixel, bus.pixel_index, cyc,
                   e.pv, e.lt, e.er, e.px, e.ix, e.at);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input logic pv, input logic lt, input logic er,
                         input logic [23:0] px, input logic [9:0] ix, input int at);
    ev_t e;
    e.pv = pv; e.lt = lt; e.er = er; e.px = px; e.ix = ix; e.at = at;
    q.push_back(e);
  endtask

  task automatic send_bit(input logic b, input int hi, input int lo);
    bus.din = 1'b1;
    tick(hi);
    bus.din = 1'b0;
    last_fall = cyc;
    tick(lo);
  endtask

  task automatic std_bit(input logic b);
    send_bit(b, b ? 40 : 20, b ? 20 : 40);
  endtask

  task automatic word(input logic [23:0] w, input int idx);
    push_ev(1'b1, 1'b0, 1'b0, w, 10'(idx), -1);
    for (int i = 23; i >= 0; i--) std_bit(w[i]);
  endtask

  // latch must land RESET_CYCLES+2 edges after the last falling edge
  task automatic frame_end(input logic err);
    push_ev(1'b0, 1'b1, err, 24'h0, 10'h0, last_fall + 2502);
    bus.din = 1'b0;
    tick(2600);
  endtask

  task automatic wait_sync(input string name, input int exp_at);
    int got;
    got = -1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (bus.in_sync) begin
        got = cyc;
        break;
      end
    end
    chk(name, got, exp_at);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pixel"}, {8'h0, bus.pixel}, 32'h0);
    chk({tag, "_pixel_valid"}, {31'h0, bus.pixel_valid}, 32'h0);
    chk({tag, "_pixel_index"}, {22'h0, bus.pixel_index}, 32'h0);
    chk({tag, "_latch"}, {31'h0, bus.latch}, 32'h0);
    chk({tag, "_bit_error"}, {31'h0, bus.bit_error}, 32'h0);
    chk({tag, "_in_sync"}, {31'h0, bus.in_sync}, 32'h0);
  endtask

  initial begin
    logic [23:0] w;
    int c;

    bus.din = 1'b0;
    rst = 1'b1;
    tick(3);
    chk_zero("reset");
    rst = 1'b0;
    c = cyc;
    wait_sync("initial_align", c + 2502);

    // single pixel
    tick(2);
    word(24'hA5F00F, 0);
    frame_end(1'b0);
    chk("single_pixel_hold", {8'h0, bus.pixel}, 32'h00A5F00F);

    // multi-pixel frame then a second frame restarting the index
    word(24'h000001, 0);
    word(24'hFFFFFF, 1);
    word(24'h800000, 2);
    frame_end(1'b0);
    word(24'h123456, 0);
    frame_end(1'b0);

    // threshold: 29-cycle highs decode 0, 31-cycle highs decode 1
    w = 24'h5A5A5A;
    push_ev(1'b1, 1'b0, 1'b0, w, 10'h0, -1);
    for (int i = 23; i >= 0; i--) send_bit(w[i], w[i] ? 31 : 29, 31);
    frame_end(1'b0);

    // partial word at latch
    w = 24'hA5F00F;
    for (int i = 23; i >= 12; i--) std_bit(w[i]);
    frame_end(1'b1);
    chk("partial_pixel_kept", {8'h0, bus.pixel}, 32'h005A5A5A);

    // 3-cycle glitch mid-word
    for (int i = 23; i >= 19; i--) std_bit(w[i]);
    bus.din = 1'b1;
    c = cyc;
    push_ev(1'b0, 1'b0, 1'b1, 24'h0, 10'h0, c + 6);
    tick(3);
    bus.din = 1'b0;
    tick(3);
    chk("glitch_in_sync", {31'h0, bus.in_sync}, 32'h0);
    chk("glitch_pixel_kept", {8'h0, bus.pixel}, 32'h005A5A5A);

    // a high pulse while aligning restarts the low count
    tick(1000);
    bus.din = 1'b1;
    tick(10);
    bus.din = 1'b0;
    c = cyc;
    wait_sync("resync_after_pulse", c + 2502);

    // stuck-high line
    tick(5);
    bus.din = 1'b1;
    c = cyc;
    push_ev(1'b0, 1'b0, 1'b1, 24'h0, 10'h0, c + 102);
    tick(120);
    chk("stuck_in_sync", {31'h0, bus.in_sync}, 32'h0);
    bus.din = 1'b0;
    c = cyc;
    wait_sync("resync_after_stuck", c + 2502);
    chk("stuck_pixel_kept", {8'h0, bus.pixel}, 32'h005A5A5A);

    // reset during bit 10, remaining bits must be ignored until resync
    tick(5);
    w = 24'h3C3C3C;
    for (int i = 23; i >= 14; i--) std_bit(w[i]);
    bus.din = 1'b1;
    tick(10);
    rst = 1'b1;
    tick(1);
    chk_zero("midframe_reset");
    bus.din = 1'b0;
    tick(2);
    rst = 1'b0;
    for (int i = 13; i >= 0; i--) std_bit(w[i]);
    wait_sync("resync_after_reset", last_fall + 2502);
    tick(2);
    word(24'hC3C3C3, 0);
    frame_end(1'b0);

    chk("events_outstanding", q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
